// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
//
// Parallel-in, serial-out result buffer. The PE array writes NUM_WDATA pixels
// in one cycle, and the writeback path drains them one pixel per read request.
// Pixels come out in strict FIFO order, and slice 0 of a group is output first.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous, active-low reset
//   i_data       : write group, NUM_WDATA pixels; slice [DAT_WIDTH-1:0] is oldest
//   i_data_vld   : write request for the whole group
//   i_data_req   : read request for one pixel
//   o_data       : read pixel, registered, 1-cycle latency from an accepted request
//   o_data_vld   : single-cycle pulse qualifying o_data
//   data_counter : occupancy in pixels
//   o_empty      : data_counter == 0
//   o_full       : no room for another whole group
//   o_ovf        : sticky overflow flag (group offered while full), cleared by reset
// -----------------------------------------------------------------------------
module output_buffer #(
    parameter int BIT_WIDTH     = 8,
    parameter int NUM_CHANNEL   = 3,
    parameter int NUM_WDATA     = 3,
    parameter int FF_DEPTH      = 8,
    parameter int FF_ADDR_WIDTH = 3,
    parameter int DAT_WIDTH     = BIT_WIDTH * NUM_CHANNEL
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DAT_WIDTH*NUM_WDATA-1:0] i_data,
    input  logic                           i_data_vld,
    input  logic                           i_data_req,
    output logic [DAT_WIDTH-1:0]           o_data,
    output logic                           o_data_vld,
    output logic [FF_ADDR_WIDTH:0]         data_counter,
    output logic                           o_empty,
    output logic                           o_full,
    output logic                           o_ovf
);

    localparam int CNT_W = FF_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_TH  = CNT_W'(FF_DEPTH - NUM_WDATA);
    localparam logic [CNT_W-1:0] WR_INC   = CNT_W'(NUM_WDATA);
    localparam logic [FF_ADDR_WIDTH-1:0] PTR_INC = FF_ADDR_WIDTH'(NUM_WDATA);

    // Pixel storage (not reset: contents are meaningless while the count is 0)
    logic [DAT_WIDTH-1:0]     mem_q [FF_DEPTH];

    logic [FF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FF_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DAT_WIDTH-1:0]     o_data_q, o_data_d;
    logic                     o_vld_q, o_vld_d;
    logic                     ovf_q, ovf_d;

    logic                     empty_w, full_w;
    logic                     wr_acc, rd_acc;
    logic [FF_ADDR_WIDTH-1:0] wr_addr [NUM_WDATA];

    // Flags come from the registered count only, so a read in the same cycle
    // never makes room for a write.
    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q > FULL_TH);

    always_comb begin
        wr_acc   = i_data_vld && !full_w;
        rd_acc   = i_data_req && !empty_w;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        o_data_d = o_data_q;
        o_vld_d  = 1'b0;
        ovf_d    = ovf_q;

        // Slot addresses for each pixel of the group; wrap naturally in the
        // pointer width so a group may straddle the end of storage.
        for (int k = 0; k < NUM_WDATA; k++) begin
            wr_addr[k] = wr_ptr_q + FF_ADDR_WIDTH'(k);
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end

        if (i_data_vld && full_w) begin
            ovf_d = 1'b1;
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + FF_ADDR_WIDTH'(1);
            o_data_d = mem_q[rd_ptr_q];
            o_vld_d  = 1'b1;
        end

        cnt_d = cnt_q + (wr_acc ? WR_INC : '0) - (rd_acc ? CNT_W'(1) : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            o_data_q <= '0;
            o_vld_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            o_data_q <= o_data_d;
            o_vld_q  <= o_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Accepted writes only ever land in free slots, so they never collide with
    // the slot being read in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < NUM_WDATA; k++) begin
                mem_q[wr_addr[k]] <= i_data[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    assign o_data       = o_data_q;
    assign o_data_vld   = o_vld_q;
    assign data_counter = cnt_q;
    assign o_empty      = empty_w;
    assign o_full       = full_w;
    assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_buffer
//
// Scoreboard bench for output_buffer. The driver updates a queue-based model
// of the buffer each cycle and pushes expected read pixels into a scoreboard
// queue; an independent monitor pops and compares whenever o_data_vld is seen.
// -----------------------------------------------------------------------------
module tb_output_buffer;

    localparam int BW    = 8;
    localparam int NCH   = 3;
    localparam int NW    = 3;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = BW * NCH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW*NW-1:0]  i_data = '0;
    logic              i_data_vld = 1'b0;
    logic              i_data_req = 1'b0;
    logic [DW-1:0]     o_data;
    logic              o_data_vld;
    logic [AW:0]       data_counter;
    logic              o_empty;
    logic              o_full;
    logic              o_ovf;

    output_buffer #(
        .BIT_WIDTH(BW), .NUM_CHANNEL(NCH), .NUM_WDATA(NW),
        .FF_DEPTH(DEPTH), .FF_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_data_vld(i_data_vld), .i_data_req(i_data_req),
        .o_data(o_data), .o_data_vld(o_data_vld),
        .data_counter(data_counter), .o_empty(o_empty), .o_full(o_full),
        .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: plain FIFO of pixels plus sticky overflow flag
    logic [DW-1:0] mq[$];
    bit            ovf_m   = 1'b0;
    bit            exp_vld = 1'b0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_data = '0;
    bit            mon_en = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs at the falling edge and advance the model to
    // the state the DUT should hold after the following rising edge.
    task automatic cyc(input bit v, input logic [DW*NW-1:0] d, input bit r);
        bit full_m, rd_m;
        @(negedge clk);
        i_data_vld = v;
        i_data     = d;
        i_data_req = r;
        full_m = (mq.size() + NW > DEPTH);
        rd_m   = r && (mq.size() != 0);
        if (rd_m) sb.push_back(mq.pop_front());
        exp_vld = rd_m;
        if (v && !full_m) begin
            for (int k = 0; k < NW; k++) mq.push_back(d[k*DW +: DW]);
        end else if (v) begin
            ovf_m = 1'b1;
        end
    endtask

    function automatic logic [DW*NW-1:0] grp(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [DW*NW-1:0] rnd_grp();
        logic [DW*NW-1:0] g;
        for (int k = 0; k < NW; k++) g[k*DW +: DW] = DW'($urandom);
        return g;
    endfunction

    // Asynchronous reset asserted between edges with stimulus still active
    task automatic do_reset();
        @(posedge clk);
        #3;
        i_data_vld = 1'b1;
        i_data_req = 1'b1;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_counter", 32'(data_counter), 0);
        chk("rst_empty",   32'(o_empty), 1);
        chk("rst_full",    32'(o_full), 0);
        chk("rst_ovf",     32'(o_ovf), 0);
        chk("rst_vld",     32'(o_data_vld), 0);
        chk("rst_data",    32'(o_data), 0);
        mq.delete();
        sb.delete();
        ovf_m = 1'b0;
        exp_vld = 1'b0;
        last_data = '0;
        // Release with a read pending: first edge after release must not pulse
        @(negedge clk);
        i_data_vld = 1'b0;
        i_data_req = 1'b1;
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("vld", 32'(o_data_vld), 32'(exp_vld));
            if (o_data_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld_sb_empty", 32'(o_data), 32'hFFFF_FFFF);
                end else begin
                    last_data = sb.pop_front();
                    chk("data", 32'(o_data), 32'(last_data));
                end
            end else begin
                chk("data_hold", 32'(o_data), 32'(last_data));
            end
            chk("counter", 32'(data_counter), 32'(mq.size()));
            chk("empty",   32'(o_empty), 32'(mq.size() == 0));
            chk("full",    32'(o_full),  32'(mq.size() + NW > DEPTH));
            chk("ovf",     32'(o_ovf),   32'(ovf_m));
        end
    end

    initial begin
        // Power-on reset
        #2;
        chk("por_counter", 32'(data_counter), 0);
        chk("por_empty",   32'(o_empty), 1);
        chk("por_full",    32'(o_full), 0);
        chk("por_vld",     32'(o_data_vld), 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Single group, three reads
        cyc(1, grp(24'h010101, 24'h020202, 24'h030303), 0);
        repeat (3) cyc(0, '0, 1);
        cyc(0, '0, 0);
        cyc(0, '0, 0);

        // Full threshold and overflow (concurrent read does not free space)
        do_reset();
        cyc(1, rnd_grp(), 0);
        cyc(1, rnd_grp(), 0);
        cyc(1, rnd_grp(), 1);
        cyc(1, rnd_grp(), 0);
        repeat (9) cyc(0, '0, 1);

        // Wrap-around from a clean pointer state
        do_reset();
        cyc(1, grp(24'hA00001, 24'hA00002, 24'hA00003), 0);
        cyc(1, grp(24'hA00004, 24'hA00005, 24'hA00006), 0);
        repeat (5) cyc(0, '0, 1);
        cyc(1, grp(24'hB00001, 24'hB00002, 24'hB00003), 0);
        cyc(1, grp(24'hB00004, 24'hB00005, 24'hB00006), 0);
        repeat (7) cyc(0, '0, 1);
        cyc(0, '0, 0);

        // Simultaneous write and read at count 3
        cyc(1, grp(24'hC00001, 24'hC00002, 24'hC00003), 0);
        cyc(1, grp(24'hD00001, 24'hD00002, 24'hD00003), 1);
        repeat (5) cyc(0, '0, 1);

        // Underflow: request held 4 cycles with one pixel stored
        cyc(1, grp(24'hE00001, 24'hE00002, 24'hE00003), 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);
        repeat (4) cyc(0, '0, 1);
        cyc(0, '0, 0);

        // Randomised traffic with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) do_reset();
            else cyc(($urandom_range(0, 2) == 0), rnd_grp(), ($urandom_range(0, 2) != 0));
        end
        repeat (10) cyc(0, '0, 1);
        cyc(0, '0, 0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
